// File: rtl/archel_pkg.sv
// Shared definitions for the archel run-control slice: run-state encoding
// and default geometry of the instruction memory.
package archel_pkg;

    localparam int DEF_INSTR_W = 16;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_CNT_W   = 16;

    // Encoding is visible on the STATE output, so the values are fixed.
    typedef enum logic [2:0] {
        ST_HALT      = 3'd0,
        ST_LOAD_HDR  = 3'd1,
        ST_LOAD_BODY = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_RUN       = 3'd4,
        ST_BURST     = 3'd5
    } state_e;

endpackage

// File: rtl/archel_loader.sv
// Program loader: accepts a length header followed by that many instruction
// words over a valid/ready stream and writes them to instruction memory from
// address 0 upward. Reports header accept, header error and load completion
// to the run controller in the same cycle as the deciding beat.
module archel_loader
    import archel_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               ld_valid_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    output logic               ld_ready_o,
    output logic               im_we_o,
    output logic [ADDR_W-1:0]  im_addr_o,
    output logic [INSTR_W-1:0] im_wdata_o,
    output logic [ADDR_W:0]    prog_len_o,
    output logic               err_o,
    output logic               hdr_ok_o,
    output logic               hdr_err_o,
    output logic               done_o
);

    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    logic               ld_ready_q;
    logic               in_body_q;
    logic [ADDR_W:0]    len_q;
    logic [ADDR_W:0]    idx_q;
    logic               im_we_q;
    logic [ADDR_W-1:0]  im_addr_q;
    logic [INSTR_W-1:0] im_wdata_q;
    logic [ADDR_W:0]    prog_len_q;
    logic               err_q;

    logic        beat;
    logic        hdr_beat;
    logic        body_beat;
    logic        hdr_bad;
    logic        last_word;
    logic [31:0] hdr_w;

    // Header is range-checked at 32 bits so a wide word can never alias
    // into the legal range through truncation.
    assign hdr_w     = 32'(ld_data_i);
    assign beat      = ld_valid_i && ld_ready_q;
    assign hdr_beat  = beat && !in_body_q;
    assign body_beat = beat && in_body_q;
    assign hdr_bad   = (hdr_w == 32'd0) || (hdr_w > 32'(DEPTH));
    assign last_word = (idx_q + IDX_ONE) == len_q;

    assign hdr_ok_o  = hdr_beat && !hdr_bad;
    assign hdr_err_o = hdr_beat && hdr_bad;
    assign done_o    = body_beat && last_word;

    // Handshake, address counter and registered memory-write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_ready_q <= 1'b0;
            in_body_q  <= 1'b0;
            len_q      <= '0;
            idx_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            prog_len_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of the others, so the later ifs below override
            // earlier ones without ordering hazards.
            im_we_q <= 1'b0;
            if (start_i) begin
                ld_ready_q <= 1'b1;
                in_body_q  <= 1'b0;
                err_q      <= 1'b0;
                idx_q      <= '0;
            end
            if (hdr_err_o) begin
                ld_ready_q <= 1'b0;
                err_q      <= 1'b1;
                prog_len_q <= '0;
            end
            if (hdr_ok_o) begin
                in_body_q <= 1'b1;
                len_q     <= hdr_w[ADDR_W:0];
                idx_q     <= '0;
            end
            if (body_beat) begin
                im_we_q    <= 1'b1;
                im_addr_q  <= idx_q[ADDR_W-1:0];
                im_wdata_q <= ld_data_i;
                idx_q      <= idx_q + IDX_ONE;
            end
            if (done_o) begin
                ld_ready_q <= 1'b0;
                in_body_q  <= 1'b0;
                prog_len_q <= len_q;
            end
        end
    end

    assign ld_ready_o = ld_ready_q;
    assign im_we_o    = im_we_q;
    assign im_addr_o  = im_addr_q;
    assign im_wdata_o = im_wdata_q;
    assign prog_len_o = prog_len_q;
    assign err_o      = err_q;

endmodule

// File: rtl/archel_runctl.sv
// Run controller for the archel core: owns the core clock-enable and reset,
// sequences program loading and provides free-run, pause, single-step and
// N-cycle burst execution. All outputs come straight from registers.
module archel_runctl
    import archel_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pause_i,
    input  logic               step_i,
    input  logic               burst_i,
    input  logic [CNT_W-1:0]   run_n_i,
    input  logic               ld_start_i,
    input  logic               ld_valid_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    output logic               ld_ready_o,
    output logic               im_we_o,
    output logic [ADDR_W-1:0]  im_addr_o,
    output logic [INSTR_W-1:0] im_wdata_o,
    output logic               cpu_en_o,
    output logic               cpu_rst_o,
    output logic [ADDR_W:0]    prog_len_o,
    output logic               err_o,
    output logic [2:0]         state_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e             state_q, state_d;
    logic               cpu_en_q, cpu_en_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               step_prev_q;

    logic load_start;
    logic step_edge;
    logic hdr_ok;
    logic hdr_err;
    logic load_done;

    // Edges are only acted on in PAUSED; elsewhere they fall away unused.
    assign step_edge = step_i && !step_prev_q;

    archel_loader #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_loader (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (load_start),
        .ld_valid_i (ld_valid_i),
        .ld_data_i  (ld_data_i),
        .ld_ready_o (ld_ready_o),
        .im_we_o    (im_we_o),
        .im_addr_o  (im_addr_o),
        .im_wdata_o (im_wdata_o),
        .prog_len_o (prog_len_o),
        .err_o      (err_o),
        .hdr_ok_o   (hdr_ok),
        .hdr_err_o  (hdr_err),
        .done_o     (load_done)
    );

    // Next-state, next clock-enable and burst-count decision.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cpu_en_d    = 1'b0;
        burst_cnt_d = burst_cnt_q;
        load_start  = 1'b0;

        if (ld_start_i && state_q != ST_LOAD_HDR && state_q != ST_LOAD_BODY) begin
            state_d     = ST_LOAD_HDR;
            load_start  = 1'b1;
            burst_cnt_d = '0;
        end else begin
            case (state_q)
                ST_HALT: ;
                ST_LOAD_HDR: begin
                    if (hdr_err) state_d = ST_HALT;
                    else if (hdr_ok) state_d = ST_LOAD_BODY;
                end
                ST_LOAD_BODY: begin
                    if (load_done) state_d = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (!pause_i) begin
                        state_d  = ST_RUN;
                        cpu_en_d = 1'b1;
                    end else if (burst_i && run_n_i != '0) begin
                        // First burst cycle starts now; count the rest.
                        state_d     = ST_BURST;
                        cpu_en_d    = 1'b1;
                        burst_cnt_d = run_n_i - CNT_ONE;
                    end else if (step_edge) begin
                        cpu_en_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pause_i) state_d = ST_PAUSED;
                    else cpu_en_d = 1'b1;
                end
                ST_BURST: begin
                    if (burst_cnt_q != '0) begin
                        cpu_en_d    = 1'b1;
                        burst_cnt_d = burst_cnt_q - CNT_ONE;
                    end else begin
                        state_d = ST_PAUSED;
                    end
                end
                default: state_d = ST_HALT;
            endcase
        end

        cpu_rst_d = (state_d == ST_HALT) || (state_d == ST_LOAD_HDR) ||
                    (state_d == ST_LOAD_BODY);
    end

    // State, core controls, burst counter and STEP history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_HALT;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            burst_cnt_q <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
            burst_cnt_q <= burst_cnt_d;
            step_prev_q <= step_i;
        end
    end

    assign cpu_en_o  = cpu_en_q;
    assign cpu_rst_o = cpu_rst_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_archel_runctl.sv
// Bench for archel_runctl: stimulus pushes expected memory writes into a
// queue that a negedge monitor drains; the monitor also profiles CPU_EN.
module tb_archel_runctl;
    import archel_pkg::*;

    localparam int INSTR_W = 16;
    localparam int DEPTH   = 1024;
    localparam int ADDR_W  = 10;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               pause, step, burst, ld_start, ld_valid;
    logic [CNT_W-1:0]   run_n;
    logic [INSTR_W-1:0] ld_data;
    logic               ld_ready, im_we, cpu_en, cpu_rst, err;
    logic [ADDR_W-1:0]  im_addr;
    logic [INSTR_W-1:0] im_wdata;
    logic [ADDR_W:0]    prog_len;
    logic [2:0]         state;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    wr_t wr_q[$];
    wr_t wr_exp;
    int  wr_count, first_wr_cyc, last_wr_cyc, last_wr_addr;
    int  en_cycles, en_pulses, run_len, max_run;
    logic en_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    archel_runctl #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pause_i    (pause),
        .step_i     (step),
        .burst_i    (burst),
        .run_n_i    (run_n),
        .ld_start_i (ld_start),
        .ld_valid_i (ld_valid),
        .ld_data_i  (ld_data),
        .ld_ready_o (ld_ready),
        .im_we_o    (im_we),
        .im_addr_o  (im_addr),
        .im_wdata_o (im_wdata),
        .cpu_en_o   (cpu_en),
        .cpu_rst_o  (cpu_rst),
        .prog_len_o (prog_len),
        .err_o      (err),
        .state_o    (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every DUT write must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (im_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write addr %0d data 0x%0h, expected none",
                             im_addr, im_wdata);
                end else begin
                    wr_exp = wr_q.pop_front();
                    check("wr_addr", 32'(im_addr), 32'(wr_exp.addr));
                    check("wr_data", 32'(im_wdata), 32'(wr_exp.data));
                end
                if (wr_count == 0) first_wr_cyc = cyc;
                last_wr_cyc  = cyc;
                last_wr_addr = int'(im_addr);
                wr_count++;
            end
            if (cpu_en === 1'b1) begin
                en_cycles++;
                if (!en_prev) en_pulses++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            en_prev = cpu_en;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        en_cycles = 0;
        en_pulses = 0;
        run_len   = 0;
        max_run   = 0;
        wr_count  = 0;
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_state"},    32'(state),    32'(ST_HALT));
        check({tag, "_cpu_en"},   32'(cpu_en),   32'd0);
        check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_im_we"},    32'(im_we),    32'd0);
        check({tag, "_im_addr"},  32'(im_addr),  32'd0);
        check({tag, "_im_wdata"}, 32'(im_wdata), 32'd0);
        check({tag, "_prog_len"}, 32'(prog_len), 32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    // Start, header, then n words base+i streamed back-to-back.
    task automatic load_prog(input int n, input logic [INSTR_W-1:0] base);
        wr_t w;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data  = INSTR_W'(n);
        tick();
        for (int i = 0; i < n; i++) begin
            ld_data = base + INSTR_W'(i);
            w.addr  = ADDR_W'(i);
            w.data  = ld_data;
            wr_q.push_back(w);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic bad_header(input string tag, input int n);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check({tag, "_hdr_err_clear"}, 32'(err),      32'd0);
        check({tag, "_hdr_ready"},     32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_data  = INSTR_W'(n);
        tick();
        ld_valid = 1'b0;
        check({tag, "_err"},      32'(err),      32'd1);
        check({tag, "_state"},    32'(state),    32'(ST_HALT));
        check({tag, "_prog_len"}, 32'(prog_len), 32'd0);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; pause = 1'b1; step = 1'b0; burst = 1'b0; run_n = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        clr_counts();
        #2 rst_n = 1'b0;
        #20;
        check_rst("rst_held");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);
        check_rst("rst_idle");

        // Three-word program, back-to-back beats.
        clr_counts();
        load_prog(3, 16'hA001);
        check("ld3_state",    32'(state),    32'(ST_PAUSED));
        check("ld3_prog_len", 32'(prog_len), 32'd3);
        check("ld3_cpu_rst",  32'(cpu_rst),  32'd0);
        check("ld3_cpu_en",   32'(cpu_en),   32'd0);
        check("ld3_ld_ready", 32'(ld_ready), 32'd0);
        tick(2);
        check("ld3_wr_count", 32'(wr_count), 32'd3);
        check("ld3_wr_span",  32'(last_wr_cyc - first_wr_cyc), 32'd2);
        check("ld3_en_cycles", 32'(en_cycles), 32'd0);

        // Illegal headers, then the full-depth program.
        clr_counts();
        bad_header("hdr0", 0);
        bad_header("hdr1025", 1025);
        check("bad_hdr_writes", 32'(wr_count), 32'd0);
        load_prog(1024, 16'h1000);
        check("ld1024_state",    32'(state),    32'(ST_PAUSED));
        check("ld1024_prog_len", 32'(prog_len), 32'd1024);
        check("ld1024_err",      32'(err),      32'd0);
        tick(2);
        check("ld1024_wr_count", 32'(wr_count),     32'd1024);
        check("ld1024_last_adr", 32'(last_wr_addr), 32'd1023);

        // Three STEP pulses while paused, one of them held long.
        clr_counts();
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick((p == 2) ? 10 : 4);
            step = 1'b0;
            tick(3);
        end
        check("step_en_cycles", 32'(en_cycles), 32'd3);
        check("step_en_pulses", 32'(en_pulses), 32'd3);
        check("step_max_run",   32'(max_run),   32'd1);
        check("step_state",     32'(state),     32'(ST_PAUSED));

        // Burst of 5 with STEP, PAUSE and BURST disturbed mid-burst.
        clr_counts();
        run_n = 16'd5;
        burst = 1'b1;
        tick();
        burst = 1'b0;
        check("burst_state", 32'(state), 32'(ST_BURST));
        step = 1'b1;
        tick();
        pause = 1'b0;
        tick();
        pause = 1'b1;
        step  = 1'b0;
        tick(2);
        burst = 1'b1;
        tick();
        burst = 1'b0;
        check("burst_end_state",  32'(state),  32'(ST_PAUSED));
        check("burst_end_cpu_en", 32'(cpu_en), 32'd0);
        tick(4);
        check("burst_en_cycles", 32'(en_cycles), 32'd5);
        check("burst_en_pulses", 32'(en_pulses), 32'd1);
        check("burst_max_run",   32'(max_run),   32'd5);

        // Zero-length burst does nothing.
        clr_counts();
        run_n = '0;
        burst = 1'b1;
        tick();
        burst = 1'b0;
        tick(3);
        check("burst0_en_cycles", 32'(en_cycles), 32'd0);
        check("burst0_state",     32'(state),     32'(ST_PAUSED));

        // Free run, then a load request pre-empts it.
        clr_counts();
        pause = 1'b0;
        tick();
        check("run_state",  32'(state),  32'(ST_RUN));
        check("run_cpu_en", 32'(cpu_en), 32'd1);
        tick(9);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("run_ld_cpu_en",   32'(cpu_en),   32'd0);
        check("run_ld_cpu_rst",  32'(cpu_rst),  32'd1);
        check("run_ld_ld_ready", 32'(ld_ready), 32'd1);
        check("run_ld_state",    32'(state),    32'(ST_LOAD_HDR));
        check("run_en_cycles",   32'(en_cycles), 32'd10);
        check("run_en_pulses",   32'(en_pulses), 32'd1);

        // Header 5, two body beats, then reset aborts the load.
        pause    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'd5;
        tick();
        for (int i = 0; i < 2; i++) begin
            ld_data = 16'hB000 + INSTR_W'(i);
            wr_exp.addr = ADDR_W'(i);
            wr_exp.data = ld_data;
            wr_q.push_back(wr_exp);
            tick();
        end
        ld_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_rst("rst_mid");
        check("rst_mid_wr_drained", 32'(wr_q.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Reload after the abort.
        load_prog(2, 16'hC000);
        check("reload_state",    32'(state),    32'(ST_PAUSED));
        check("reload_prog_len", 32'(prog_len), 32'd2);
        check("reload_err",      32'(err),      32'd0);
        tick(2);
        check("final_wr_drained", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
